// File: rtl/max7219_pkg.sv
// max7219_pkg
// Shared definitions for the MAX7219 chain sequencer: register addresses,
// the sequencer state enum, the 16-bit command word type, and the helper
// that replicates one command word across every device in the chain.
package max7219_pkg;

  typedef logic [15:0] max7219_word_t;

  // MAX7219 register addresses (upper byte of a command word)
  localparam logic [7:0] NOOP      = 8'h00;
  localparam logic [7:0] DIGIT0    = 8'h01;
  localparam logic [7:0] DECODE    = 8'h09;
  localparam logic [7:0] INTENSITY = 8'h0A;
  localparam logic [7:0] SCANLIM   = 8'h0B;
  localparam logic [7:0] SHUTDOWN  = 8'h0C;
  localparam logic [7:0] TEST      = 8'h0F;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    SNAP  = 3'd1,
    ROWS  = 3'd2,
    GAP   = 3'd3,
    INTEN = 3'd4
  } seq_state_t;

  // Upper bound on chain length supported by max7219_fill.
  localparam int MAX_DEV      = 64;
  localparam int MAX_TX_WIDTH = MAX_DEV * 16;

  // Replicate one command word into the low n_dev device slots; slots above
  // n_dev are zero so callers can truncate to their own transaction width.
  function automatic logic [MAX_TX_WIDTH-1:0] max7219_fill(input max7219_word_t w,
                                                           input int n_dev);
    logic [MAX_TX_WIDTH-1:0] v;
    v = '0;
    for (int d = 0; d < MAX_DEV; d++) begin
      if (d < n_dev) v[16*d +: 16] = w;
    end
    return v;
  endfunction

endpackage

// File: rtl/max7219_sequencer.sv
// max7219_sequencer
// Schedules full-chain transactions to the MAX7219 SPI shifter: the init
// command set after reset (and every REINIT_FRAMES frames), then the eight
// digit rows of a frame snapshot, an idle gap, and an optional intensity
// command between frames.
// Ports:
//   i_Clk, i_Rst          clock, asynchronous active-high reset
//   i_Frame               pixel bytes [digit row][matrix row][matrix col]
//   i_Intensity(_Update)  intensity value and its 1-cycle load strobe
//   o_Tx_Data/o_Tx_Valid  transaction to the shifter, device d in [16d+15:16d]
//   i_Tx_Ready            shifter idle
//   o_Init_Done           first init set accepted
//   o_Frame_Done          1-cycle pulse after row 7 is accepted
//   o_Dbg_State           current sequencer state
module max7219_sequencer
  import max7219_pkg::*;
#(
  parameter int          DISP_COLUMNS         = 4,
  parameter int          DISP_ROWS            = 5,
  parameter int          N_DEV                = DISP_COLUMNS * DISP_ROWS,
  parameter int          TX_WIDTH             = N_DEV * 16,
  parameter int          REFRESH_DELAY_CLOCKS = 1200,
  parameter int          REINIT_FRAMES        = 0,
  parameter logic [3:0]  DEFAULT_INTENSITY    = 4'h8
) (
  input  logic                                              i_Clk,
  input  logic                                              i_Rst,
  input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0]  i_Frame,
  input  logic [3:0]                                        i_Intensity,
  input  logic                                              i_Intensity_Update,
  output logic [TX_WIDTH-1:0]                               o_Tx_Data,
  output logic                                              o_Tx_Valid,
  input  logic                                              i_Tx_Ready,
  output logic                                              o_Init_Done,
  output logic                                              o_Frame_Done,
  output logic [2:0]                                        o_Dbg_State
);

  typedef logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0] row_bytes_t;
  typedef logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0] frame_t;

  localparam int GAP_W = $clog2(REFRESH_DELAY_CLOCKS + 1);
  localparam int FRM_W = (REINIT_FRAMES > 1) ? $clog2(REINIT_FRAMES) : 1;

  // Handshake: a word transfers on any clock edge where o_Tx_Valid and
  // i_Tx_Ready are both high; o_Tx_Data is frozen while o_Tx_Valid is high,
  // and o_Tx_Valid is always low for at least one cycle after a transfer.

  seq_state_t            r_state, w_state;
  logic [2:0]            r_idx, w_idx;
  logic                  r_valid, w_valid;
  logic [TX_WIDTH-1:0]   r_data, w_data;
  logic [GAP_W-1:0]      r_gap, w_gap;
  logic [FRM_W-1:0]      r_frm, w_frm;
  logic                  r_due, w_due;
  logic [3:0]            r_inten;
  logic                  r_pend, w_pend_clr;
  logic                  r_init_done, w_init_done;
  logic                  r_frame_done, w_frame_done;
  frame_t                r_snap;
  logic                  w_accept, w_wrap;

  function automatic logic [TX_WIDTH-1:0] row_word(input row_bytes_t rb, input logic [2:0] r);
    logic [TX_WIDTH-1:0] v;
    v = '0;
    for (int y = 0; y < DISP_ROWS; y++) begin
      for (int x = 0; x < DISP_COLUMNS; x++) begin
        v[16*(y*DISP_COLUMNS+x) +: 16] = {4'h0, {1'b0, r} + 4'd1, rb[y][x]};
      end
    end
    return v;
  endfunction

  function automatic max7219_word_t init_word(input logic [2:0] idx, input logic [3:0] inten);
    case (idx)
      3'd0:    init_word = {TEST, 8'h00};
      3'd1:    init_word = {SCANLIM, 8'h07};
      3'd2:    init_word = {DECODE, 8'h00};
      3'd3:    init_word = {INTENSITY, 4'h0, inten};
      3'd4:    init_word = {SHUTDOWN, 8'h01};
      default: init_word = {NOOP, 8'h00};
    endcase
  endfunction

  function automatic seq_state_t after_gap(input logic due, input logic pend);
    if (due)       after_gap = INIT;
    else if (pend) after_gap = INTEN;
    else           after_gap = SNAP;
  endfunction

  assign w_accept = r_valid & i_Tx_Ready;
  assign w_wrap   = (REINIT_FRAMES != 0) && (r_frm == FRM_W'(REINIT_FRAMES - 1));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_state <= INIT;
    else       r_state <= w_state;
  end

  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_valid      = r_valid;
    w_data       = r_data;
    w_gap        = r_gap;
    w_frm        = r_frm;
    w_due        = r_due;
    w_pend_clr   = 1'b0;
    w_init_done  = r_init_done;
    w_frame_done = 1'b0;
    case (r_state)
      INIT: begin
        if (!r_valid) begin
          w_valid = 1'b1;
          w_data  = TX_WIDTH'(max7219_fill(init_word(r_idx, r_inten), N_DEV));
        end else if (w_accept) begin
          w_valid = 1'b0;
          if (r_idx == 3'd3) w_pend_clr = 1'b1;
          if (r_idx == 3'd4) begin
            w_state     = SNAP;
            w_idx       = 3'd0;
            w_init_done = 1'b1;
            w_due       = 1'b0;
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end
      end
      // Row 0 is loaded straight from i_Frame while the snapshot is taken,
      // so the gap before it is the single SNAP cycle.
      SNAP: begin
        w_valid = 1'b1;
        w_data  = row_word(i_Frame[0], 3'd0);
        w_state = ROWS;
        w_idx   = 3'd0;
      end
      ROWS: begin
        if (!r_valid) begin
          w_valid = 1'b1;
          w_data  = row_word(r_snap[r_idx], r_idx);
        end else if (w_accept) begin
          w_valid = 1'b0;
          if (r_idx == 3'd7) begin
            w_frame_done = 1'b1;
            w_idx        = 3'd0;
            w_due        = w_wrap;
            if (REINIT_FRAMES != 0) w_frm = w_wrap ? '0 : r_frm + FRM_W'(1);
            // The next state's own load cycle is the last idle cycle, so
            // GAP itself only covers REFRESH_DELAY_CLOCKS-1 cycles.
            if (REFRESH_DELAY_CLOCKS <= 1) begin
              w_state = after_gap(w_wrap, r_pend | i_Intensity_Update);
            end else begin
              w_state = GAP;
              w_gap   = '0;
            end
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end
      end
      GAP: begin
        if (r_gap == GAP_W'(REFRESH_DELAY_CLOCKS - 2)) begin
          w_state = after_gap(r_due, r_pend | i_Intensity_Update);
        end else begin
          w_gap = r_gap + GAP_W'(1);
        end
      end
      INTEN: begin
        if (!r_valid) begin
          w_valid = 1'b1;
          w_data  = TX_WIDTH'(max7219_fill({INTENSITY, 4'h0, r_inten}, N_DEV));
        end else if (w_accept) begin
          w_valid    = 1'b0;
          w_pend_clr = 1'b1;
          w_state    = SNAP;
        end
      end
      default: w_state = INIT;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_idx        <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_gap        <= '0;
      r_frm        <= '0;
      r_due        <= 1'b0;
      r_inten      <= DEFAULT_INTENSITY;
      r_pend       <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_snap       <= '0;
    end else begin
      r_idx        <= w_idx;
      r_valid      <= w_valid;
      r_data       <= w_data;
      r_gap        <= w_gap;
      r_frm        <= w_frm;
      r_due        <= w_due;
      r_init_done  <= w_init_done;
      r_frame_done <= w_frame_done;
      if (r_state == SNAP) r_snap <= i_Frame;
      // A new request wins over a same-cycle clear so it is never lost.
      if (i_Intensity_Update) begin
        r_inten <= i_Intensity;
        r_pend  <= 1'b1;
      end else if (w_pend_clr) begin
        r_pend  <= 1'b0;
      end
    end
  end

  assign o_Tx_Data    = r_data;
  assign o_Tx_Valid   = r_valid;
  assign o_Init_Done  = r_init_done;
  assign o_Frame_Done = r_frame_done;
  assign o_Dbg_State  = r_state;

endmodule

// File: tb/tb_max7219_sequencer.sv
module tb_max7219_sequencer;

  localparam int COLS   = 4;
  localparam int ROWS   = 5;
  localparam int NDEV   = COLS * ROWS;
  localparam int TXW    = NDEV * 16;
  localparam int GAP_D  = 12;
  localparam int REINIT = 2;

  typedef logic [0:7][ROWS-1:0][COLS-1:0][7:0] frame_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_t           frame;
  logic [3:0]       inten;
  logic             inten_upd;
  logic [TXW-1:0]   tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             init_done;
  logic             frame_done;
  logic [2:0]       dbg_state;

  max7219_sequencer #(
    .DISP_COLUMNS(COLS),
    .DISP_ROWS(ROWS),
    .REFRESH_DELAY_CLOCKS(GAP_D),
    .REINIT_FRAMES(REINIT),
    .DEFAULT_INTENSITY(4'h8)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Frame(frame),
    .i_Intensity(inten),
    .i_Intensity_Update(inten_upd),
    .o_Tx_Data(tx_data),
    .o_Tx_Valid(tx_valid),
    .i_Tx_Ready(tx_ready),
    .o_Init_Done(init_done),
    .o_Frame_Done(frame_done),
    .o_Dbg_State(dbg_state)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [TXW-1:0] act, input logic [TXW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    fails++;
    $display("FAIL timeout_%s actual=no_event expected=event", name);
  endtask

  // ---------------- behavioural model ----------------
  // Transactions are tags: 0..4 init commands, 10+r digit row r, 20 intensity.
  int              exp_q[$];
  int              cur_tag = -1;
  logic [TXW-1:0]  cur_data;
  bit              prev_valid;
  int              low_run, exp_low;
  bit              gap_mode;
  logic [3:0]      m_inten;
  bit              m_pend, m_due, m_init_done, m_fd;
  int              m_frames;
  frame_t          m_snap, last_frame;
  int              frames_total = 0;
  int              n_inten_tx = 0;
  bit              lit_first, lit_init3, lit_a5, lit_inten;

  task automatic push_rows();
    for (int r = 0; r < 8; r++) exp_q.push_back(10 + r);
  endtask

  task automatic push_init();
    for (int k = 0; k < 5; k++) exp_q.push_back(k);
  endtask

  function automatic logic [TXW-1:0] exp_word(input int tag);
    logic [TXW-1:0] v;
    logic [15:0]    w;
    int             r;
    v = '0;
    if (tag >= 10 && tag <= 17) begin
      r = tag - 10;
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++)
          v[16*(y*COLS+x) +: 16] = {4'h0, 4'(r + 1), m_snap[r][y][x]};
    end else begin
      case (tag)
        0:       w = 16'h0F00;
        1:       w = 16'h0B07;
        2:       w = 16'h0900;
        3:       w = {12'h0A0, m_inten};
        4:       w = 16'h0C01;
        20:      w = {12'h0A0, m_inten};
        default: w = 16'hDEAD;
      endcase
      for (int d = 0; d < NDEV; d++) v[16*d +: 16] = w;
    end
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit accept;
    if (rst) begin
      check("rst_valid", TXW'(tx_valid), '0);
      check("rst_data", tx_data, '0);
      check("rst_init_done", TXW'(init_done), '0);
      check("rst_frame_done", TXW'(frame_done), '0);
      exp_q.delete();
      push_init();
      push_rows();
      cur_tag = -1; prev_valid = 0; low_run = 0; exp_low = 1; gap_mode = 0;
      m_inten = 4'h8; m_pend = 0; m_due = 0; m_init_done = 0; m_fd = 0; m_frames = 0;
      lit_first = 1; lit_init3 = 1;
    end else begin
      check("init_done", TXW'(init_done), TXW'(m_init_done));
      check("frame_done", TXW'(frame_done), TXW'(m_fd));
      m_fd = 0;
      if (tx_valid) begin
        if (prev_valid) begin
          check("hold_data", tx_data, cur_data);
        end else begin
          if (exp_q.size() == 0) begin
            if (m_due) begin push_init(); m_due = 0; end
            else if (m_pend) exp_q.push_back(20);
            push_rows();
          end
          check("idle_cycles", TXW'(low_run), TXW'(exp_low));
          cur_tag = exp_q.pop_front();
          if (cur_tag == 10) m_snap = last_frame;
          if (cur_tag == 20) n_inten_tx++;
          cur_data = exp_word(cur_tag);
          check("tx_word", tx_data, cur_data);
          if (lit_first) begin
            check("lit_first_dev0", TXW'(tx_data[15:0]), TXW'(16'h0F00));
            check("lit_first_dev19", TXW'(tx_data[TXW-1 -: 16]), TXW'(16'h0F00));
            lit_first = 0;
          end
          if (cur_tag == 3 && lit_init3) begin
            check("lit_init_intensity", TXW'(tx_data[15:0]), TXW'(16'h0A08));
            lit_init3 = 0;
          end
          if (cur_tag == 13 && lit_a5) begin
            check("lit_row3_dev0", TXW'(tx_data[15:0]), TXW'(16'h04A5));
            check("lit_row3_dev1", TXW'(tx_data[31:16]), TXW'(16'h0400));
            lit_a5 = 0;
          end
          if (cur_tag == 20 && lit_inten) begin
            check("lit_inten_dev0", TXW'(tx_data[15:0]), TXW'(16'h0A0C));
            check("lit_inten_dev19", TXW'(tx_data[TXW-1 -: 16]), TXW'(16'h0A0C));
            lit_inten = 0;
          end
          low_run = 0;
          gap_mode = 0;
        end
      end else begin
        low_run++;
      end
      accept = tx_valid && tx_ready;
      if (inten_upd) begin
        m_inten = inten;
        m_pend  = 1;
      end else if (accept && (cur_tag == 3 || cur_tag == 20)) begin
        m_pend = 0;
      end
      if (accept) begin
        exp_low = 1;
        if (cur_tag == 4) m_init_done = 1;
        if (cur_tag == 17) begin
          m_fd = 1;
          frames_total++;
          m_frames++;
          if (m_frames == REINIT) begin m_frames = 0; m_due = 1; end
          exp_low  = GAP_D;
          gap_mode = 1;
        end
      end
      prev_valid = tx_valid && !accept;
    end
    last_frame = frame;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input int n, input int limit);
    int start;
    int c;
    start = frames_total;
    c = 0;
    while (frames_total < start + n && c < limit) begin step(1); c++; end
    if (c >= limit) note_timeout("frame");
  endtask

  task automatic wait_tag(input int tag, input int limit);
    int c;
    c = 0;
    while (!(tx_valid && cur_tag == tag) && c < limit) begin step(1); c++; end
    if (c >= limit) note_timeout("tag");
  endtask

  task automatic pulse_inten(input logic [3:0] v);
    inten = v;
    inten_upd = 1'b1;
    step(1);
    inten_upd = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    bit allow;
    tx_ready  = 1'b1;
    inten     = 4'h0;
    inten_upd = 1'b0;
    frame     = '0;
    frame[3][0][0] = 8'hA5;
    lit_a5    = 1;
    lit_inten = 0;
    step(3);
    rst = 1'b0;

    // init set + first frame with a single lit byte
    wait_frames(1, 500);

    // two intensity requests inside one gap -> a single 0x0A0C command
    lit_inten = 1;
    n0 = n_inten_tx;
    step(1);
    pulse_inten(4'd3);
    step(1);
    pulse_inten(4'd12);
    wait_frames(1, 500);
    check("inten_tx_count", TXW'(n_inten_tx - n0), TXW'(1));

    // re-init follows this second frame; stall and frame change in the next one
    wait_tag(12, 500);
    frame[0][1][2] = 8'h3C;
    frame[5][4][3] = 8'hC3;
    wait_tag(14, 500);
    tx_ready = 1'b0;
    step(50);
    tx_ready = 1'b1;
    wait_frames(2, 800);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0)
        frame[$urandom_range(0, 7)][$urandom_range(0, ROWS-1)][$urandom_range(0, COLS-1)] = 8'($urandom);
      allow = (gap_mode && low_run < GAP_D - 4) || (!gap_mode && cur_tag >= 10 && cur_tag <= 17);
      if (allow && $urandom_range(0, 15) == 0) begin
        inten = 4'($urandom);
        inten_upd = 1'b1;
      end else begin
        inten_upd = 1'b0;
      end
      step(1);
    end
    inten_upd = 1'b0;
    tx_ready  = 1'b1;

    // reset in the middle of a stalled row
    wait_tag(15, 800);
    tx_ready = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    tx_ready = 1'b1;
    wait_frames(1, 500);
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/max7219_sequencer.md
# max7219_sequencer

Transaction scheduler between the frame source (pattern generator / frame buffer) and the MAX7219 SPI shifter for the 4x5 chain of 8x8 matrices. After reset it issues the MAX7219 init command set to every device in the chain, then loops refreshing the 8 digit rows from a snapshot of the frame. Intensity-change requests and periodic re-init are interleaved between frames. Each output transaction is one full-chain shift: one 16-bit word per device.

## Interface
- `DISP_COLUMNS`, default 4: matrices per chain row.
- `DISP_ROWS`, default 5: matrix rows.
- `N_DEV`, default DISP_COLUMNS*DISP_ROWS: derived; number of devices.
- `TX_WIDTH`, default N_DEV*16: derived; transaction width.
- `REFRESH_DELAY_CLOCKS`, default 1200: idle gap between frames, in clocks (≥1).
- `REINIT_FRAMES`, default 0: re-send the init set every N frames; 0 disables re-init.
- `DEFAULT_INTENSITY`, default 4'h8: intensity after reset.
- `i_Clk  in  1`: system clock (12 MHz).
- `i_Rst  in  1`: reset; **asynchronous, active-high**.
- `i_Frame  in  [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0]`: pixel bytes per digit row, MSB-first per byte.
- `i_Intensity  in  4`: new intensity value.
- `i_Intensity_Update  in  1`: 1-cycle request to apply i_Intensity.
- `o_Tx_Data  out  TX_WIDTH`: transaction; device d = row*DISP_COLUMNS+col occupies bits [16d+15:16d]; the shifter sends the MSB first.
- `o_Tx_Valid  out  1`: transaction present.
- `i_Tx_Ready  in  1`: shifter idle; it drops for the whole shift and latch.
- `o_Init_Done  out  1`: high once the first init set has been accepted.
- `o_Frame_Done  out  1`: 1-cycle pulse on acceptance of row 7.

## Operation
- Transfer occurs on o_Tx_Valid && i_Tx_Ready. o_Tx_Data is stable while o_Tx_Valid is high.
- The word is identical for all devices, except in ROWS.
- States:
  - **INIT**: five commands in order.
    - 0x0F00: display test off.
    - 0x0B07: scan limit 7.
    - 0x0900: no decode.
    - 0x0A0i: i = intensity register.
    - 0x0C01: normal operation.
  - **SNAP**: one cycle. Latches i_Frame into the snapshot register.
  - **ROWS**: r = 0..7. Word for device d is {4'h0, 4'(r+1), snapshot[r][d]}.
  - **GAP**: counts REFRESH_DELAY_CLOCKS cycles.
  - **INTEN**: single 0x0A0i command.
- Transitions:
  - Reset → INIT.
  - INIT (5th accepted) → SNAP → ROWS.
  - ROWS (r=7 accepted) → GAP.
  - GAP end, by priority:
    1. re-init due → INIT.
    2. intensity pending → INTEN.
    3. otherwise → SNAP.
  - INTEN accepted → SNAP.
- Intensity request: i_Intensity_Update loads the intensity register and sets pending.
  - pending clears on acceptance of any 0x0A command (INIT or INTEN).
  - A request in the same cycle as that acceptance leaves pending set.
  - The latest request wins.
- Re-init: frame counter increments on o_Frame_Done and wraps at REINIT_FRAMES. It is due when it wraps. Inactive if REINIT_FRAMES=0.
- Reset mid-transaction: state → INIT, counters cleared, pending cleared, intensity → DEFAULT_INTENSITY. The shifter is reset by the same i_Rst.

## Timing
- Reset values: o_Tx_Valid=0, o_Tx_Data=0, o_Init_Done=0, o_Frame_Done=0.
- First o_Tx_Valid: the first clock after reset deassertion.
- All outputs are registered. After acceptance, o_Tx_Valid drops for exactly one cycle before the next word, even if i_Tx_Ready stays high.
- o_Init_Done rises the cycle after the 5th INIT acceptance. It stays high through later re-inits.
- Snapshot is taken only in SNAP. Changes to i_Frame during ROWS do not affect the current frame (no tearing).
- GAP lasts exactly REFRESH_DELAY_CLOCKS cycles: from the cycle after the row-7 acceptance to the cycle before the next state's first o_Tx_Valid.

## Structure
- Package `max7219_pkg` holds:
  - register address constants: NOOP, DIGIT0, DECODE, INTENSITY, SCANLIM, SHUTDOWN, TEST.
  - state enum: INIT, SNAP, ROWS, GAP, INTEN.
  - `max7219_word_t` typedef (16-bit).
- No sub-module. The word replication/packing is a package function `max7219_fill(word_t)`.

## Test plan
- Reset release, i_Tx_Ready tied 1 → five transactions of all-0x0F00, 0x0B07, 0x0900, 0x0A08, 0x0C01 replicated ×20. o_Init_Done rises after the 5th.
- i_Frame[3][0][0]=8'hA5, others 0 → row-3 transaction has bits [15:0]=16'h04A5 and all other devices 16'h0400. o_Frame_Done pulses on the row-7 acceptance.
- i_Tx_Ready low for 50 cycles mid-ROWS → o_Tx_Valid and o_Tx_Data held unchanged for all 50 cycles. No row is skipped.
- Two i_Intensity_Update pulses (3, then 12) in one GAP → exactly one INTEN transaction, of all-0x0A0C, before the next SNAP.
- REINIT_FRAMES=2 → INIT set re-sent after every 2nd o_Frame_Done. i_Frame changed during ROWS appears only in the following frame.
- i_Rst asserted while i_Tx_Ready=0 mid-ROWS → next cycle o_Tx_Valid=0 and o_Init_Done=0. After release, the sequence restarts with 0x0F00 and intensity 0x0A08.
